// File: rtl/dm_access_ctrl_pkg.sv
// dm_pkg: shared definitions for the data-memory access controller.
// Holds the memory access type codes, the controller state encoding, the
// default bus timeout and a helper that folds unused load codes onto word.
package dm_pkg;

    // Access type codes as presented on mem_type
    localparam logic [2:0] MT_W  = 3'b000;
    localparam logic [2:0] MT_B  = 3'b001;
    localparam logic [2:0] MT_BU = 3'b010;
    localparam logic [2:0] MT_H  = 3'b011;
    localparam logic [2:0] MT_HU = 3'b100;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // REQ cycles without bus_ack before a bus error is raised
    localparam int DEFAULT_TIMEOUT = 255;

    // Load codes above MT_HU have no meaning of their own and behave as word
    function automatic logic [2:0] load_type(input logic [2:0] t);
        return (t > MT_HU) ? MT_W : t;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// dm_bus_if: req/ack handshake towards the variable-latency data memory.
// Ports:
//   bus_req   transaction request (controller -> memory)
//   bus_we    write strobe
//   bus_addr  word-aligned byte address
//   bus_be    byte enables
//   bus_wdata lane-replicated store data
//   bus_ack   transaction complete (memory -> controller)
//   bus_rdata read data, valid with bus_ack on a read
interface dm_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dm_access_ctrl_ld_extend.sv
// ld_extend: combinational lane select and sign/zero extension of a load.
// Ports:
//   ld_type  access type (already folded so that 101..111 read as word)
//   addr_lo  byte offset of the access inside the word
//   raw      32-bit word returned by the memory
//   result   extended load value
module ld_extend
    import dm_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword out of the word
    always_comb begin
        byte_lane = raw[7:0];
        case (addr_lo)
            2'd0: byte_lane = raw[7:0];
            2'd1: byte_lane = raw[15:8];
            2'd2: byte_lane = raw[23:16];
            2'd3: byte_lane = raw[31:24];
            default: byte_lane = raw[7:0];
        endcase
        half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    // Extend the selected lane according to the access type
    always_comb begin
        result = raw;
        case (ld_type)
            MT_B:    result = {{24{byte_lane[7]}}, byte_lane};
            MT_BU:   result = {24'd0, byte_lane};
            MT_H:    result = {{16{half_lane[15]}}, half_lane};
            MT_HU:   result = {16'd0, half_lane};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: MEM-stage controller between the pipeline and a
// variable-latency data-memory bus.
// Ports:
//   clk, reset         clock (rising edge) and asynchronous active-high reset
//   mem_valid/we/type  MEM-stage access request, direction and size/sign
//   mem_addr/wdata     byte address and store data
//   stall              hold the pipeline while a transaction is outstanding
//   ld_data/ld_valid   registered extended load result and its one-cycle pulse
//   exc_adel/exc_ades  combinational load/store address exceptions
//   exc_bus            one-cycle pulse on bus timeout
//   bus                req/ack memory bus (master side)
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        ld_valid,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        exc_bus,
    dm_bus_if.master    bus
);

    logic [1:0]       state;
    logic [CNT_W-1:0] count;
    logic [2:0]       lat_type;
    logic [1:0]       lat_lo;
    logic             lat_we;

    logic [2:0]  eff_type;
    logic        misaligned;
    logic        store_illegal;
    logic        bad_access;
    logic        in_idle;
    logic        accept;
    logic [3:0]  next_be;
    logic [31:0] next_wdata;
    logic [31:0] ext_data;

    // Classify the presented access: stores keep their raw code so illegal
    // codes can be caught, loads fold unused codes onto word.
    always_comb begin
        eff_type      = mem_we ? mem_type : load_type(mem_type);
        misaligned    = 1'b0;
        case (eff_type)
            MT_W:        misaligned = |mem_addr[1:0];
            MT_H, MT_HU: misaligned = mem_addr[0];
            default:     misaligned = 1'b0;
        endcase
        store_illegal = mem_we && !(mem_type inside {MT_W, MT_B, MT_H});
        bad_access    = misaligned || store_illegal;
    end

    // Exceptions and stall are only meaningful for a new access in IDLE;
    // in DONE the held mem_valid belongs to the instruction just completed.
    always_comb begin
        in_idle  = (state == ST_IDLE);
        accept   = in_idle && mem_valid && !bad_access;
        exc_adel = in_idle && mem_valid && !mem_we && bad_access;
        exc_ades = in_idle && mem_valid && mem_we && bad_access;
        stall    = accept || (state == ST_REQ);
    end

    // Byte enables and lane replication so the memory can write any lane
    // straight from bus_wdata without its own shifter.
    always_comb begin
        next_be    = 4'b1111;
        next_wdata = mem_wdata;
        if (mem_we) begin
            case (mem_type)
                MT_B: begin
                    next_be    = 4'b0001 << mem_addr[1:0];
                    next_wdata = {4{mem_wdata[7:0]}};
                end
                MT_H: begin
                    next_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
                    next_wdata = {2{mem_wdata[15:0]}};
                end
                default: begin
                    next_be    = 4'b1111;
                    next_wdata = mem_wdata;
                end
            endcase
        end
    end

    ld_extend u_ld_extend (
        .ld_type (lat_type),
        .addr_lo (lat_lo),
        .raw     (bus.bus_rdata),
        .result  (ext_data)
    );

    // Transaction FSM. The exc_bus register doubles as the error flag of the
    // completed transaction: it is set on the REQ->DONE edge only when the
    // timeout fired, so it is high exactly for the DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            lat_type      <= MT_W;
            lat_lo        <= 2'd0;
            lat_we        <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
            ld_data       <= '0;
            ld_valid      <= 1'b0;
            exc_bus       <= 1'b0;
        end else begin
            ld_valid <= 1'b0;
            exc_bus  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_type      <= eff_type;
                        lat_lo        <= mem_addr[1:0];
                        lat_we        <= mem_we;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_we;
                        bus.bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus.bus_be    <= next_be;
                        bus.bus_wdata <= next_wdata;
                        count         <= '0;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (!lat_we) begin
                            ld_data  <= ext_data;
                            ld_valid <= 1'b1;
                        end
                        state <= ST_DONE;
                    end else if (count == CNT_W'(TIMEOUT - 1)) begin
                        bus.bus_req <= 1'b0;
                        ld_data     <= '0;
                        exc_bus     <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench for dm_access_ctrl.
// A driver issues accesses and pushes the expected bus request and load
// result into queues; a monitor pops them when the DUT raises bus_req or
// pulses ld_valid/exc_bus. A responder plays a memory with a chosen latency
// and drives spurious acks whenever bus_req is low.
module tb_dm_access_ctrl;
    import dm_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_we;
    logic [2:0]  mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        exc_adel;
    logic        exc_ades;
    logic        exc_bus;

    dm_bus_if bus_if ();

    dm_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_type  (mem_type),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .ld_data   (ld_data),
        .ld_valid  (ld_valid),
        .exc_adel  (exc_adel),
        .exc_ades  (exc_ades),
        .exc_bus   (exc_bus),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic        ldv;
        logic        excb;
        logic [31:0] data;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int          checks = 0;
    int          errors = 0;
    int          rsp_lat = 0;
    logic [31:0] rsp_data = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access size in bytes
    function automatic int acc_size(input logic we, input logic [2:0] t);
        int code;
        code = (!we && t > 3'd4) ? 0 : int'(t);
        case (code)
            0:       return 4;
            1, 2:    return 1;
            3, 4:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] t, input logic [31:0] addr);
        if (we && !(t == 3'd0 || t == 3'd1 || t == 3'd3))
            return 1'b0;
        return (int'(addr[1:0]) % acc_size(we, t)) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] t, input int lo, input logic [31:0] rdata);
        logic [31:0] v;
        case (t)
            3'd1, 3'd2: begin
                v = (rdata >> (8 * lo)) % 256;
                if (t == 3'd1 && v >= 128) v = v - 256;
            end
            3'd3, 3'd4: begin
                v = (rdata >> (16 * (lo / 2))) % 65536;
                if (t == 3'd3 && v >= 32768) v = v - 65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] exp_be(input logic we, input logic [2:0] t, input int lo);
        if (!we) return 4'hF;
        if (t == 3'd1) return 4'(1 << lo);
        if (t == 3'd3) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic we, input logic [2:0] t, input logic [31:0] w);
        if (we && t == 3'd1) return (w % 256) * 32'h0101_0101;
        if (we && t == 3'd3) return (w % 65536) * 32'h0001_0001;
        return w;
    endfunction

    // Memory responder: ack after rsp_lat REQ cycles, random acks when idle
    initial begin
        int rsp_wait;
        rsp_wait = 0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.bus_req) begin
                if (rsp_wait == rsp_lat) begin
                    bus_if.bus_ack   = 1'b1;
                    bus_if.bus_rdata = rsp_data;
                end else begin
                    bus_if.bus_ack   = 1'b0;
                    bus_if.bus_rdata = $urandom;
                end
                rsp_wait++;
            end else begin
                bus_if.bus_ack   = 1'($urandom_range(0, 1));
                bus_if.bus_rdata = $urandom;
                rsp_wait = 0;
            end
        end
    end

    // Monitor: compare bus requests and completion pulses against the queues
    initial begin
        req_t cur;
        res_t r;
        logic prev_req;
        logic have_cur;
        prev_req = 1'b0;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.bus_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    checkOutput("unexpected bus_req", 32'd1, 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur = req_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus_if.bus_req && have_cur) begin
                checkOutput("bus_we", 32'(bus_if.bus_we), 32'(cur.we));
                checkOutput("bus_addr", bus_if.bus_addr, cur.addr);
                checkOutput("bus_be", 32'(bus_if.bus_be), 32'(cur.be));
                checkOutput("bus_wdata", bus_if.bus_wdata, cur.wdata);
            end
            if (ld_valid || exc_bus) begin
                if (res_q.size() == 0) begin
                    checkOutput("unexpected completion pulse", {30'd0, ld_valid, exc_bus}, 32'd0);
                end else begin
                    r = res_q.pop_front();
                    checkOutput("ld_valid", 32'(ld_valid), 32'(r.ldv));
                    checkOutput("exc_bus", 32'(exc_bus), 32'(r.excb));
                    checkOutput("ld_data", ld_data, r.data);
                end
            end
            prev_req = bus_if.bus_req;
        end
    end

    // Issue one access; called just after a rising edge with the DUT idle
    task automatic applyStimulus(input logic we, input logic [2:0] t, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
        bit legal;
        int req_cycles;
        int n;
        mem_valid = 1'b1;
        mem_we    = we;
        mem_type  = t;
        mem_addr  = addr;
        mem_wdata = wdata;
        rsp_lat   = lat;
        rsp_data  = rdata;
        legal     = is_legal(we, t, addr);
        req_cycles = (lat < TO) ? lat + 1 : TO;
        if (legal) begin
            req_q.push_back('{we: we, addr: {addr[31:2], 2'b00},
                              be: exp_be(we, t, int'(addr[1:0])),
                              wdata: exp_wdata(we, t, wdata)});
            if (!we || lat >= TO)
                res_q.push_back('{ldv: (!we && lat < TO), excb: (lat >= TO),
                                  data: (lat >= TO) ? 32'd0 : exp_load(t, int'(addr[1:0]), rdata)});
        end
        @(negedge clk);
        checkOutput("exc_adel", 32'(exc_adel), 32'(!legal && !we));
        checkOutput("exc_ades", 32'(exc_ades), 32'(!legal && we));
        checkOutput("stall at issue", 32'(stall), 32'(legal));
        if (legal) begin
            n = 1;
            while (n < 300) begin
                @(posedge clk);
                @(negedge clk);
                if (!stall) break;
                n++;
            end
            checkOutput("stall cycles", 32'(n), 32'(1 + req_cycles));
        end
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_we    = 1'($urandom_range(0, 1));
        mem_type  = 3'($urandom_range(0, 7));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted while a load waits in REQ: bus_req must drop at once
    task automatic reset_mid_req();
        mem_valid = 1'b1;
        mem_we    = 1'b0;
        mem_type  = MT_W;
        mem_addr  = 32'h0000_6000;
        mem_wdata = $urandom;
        rsp_lat   = 255;
        req_q.push_back('{we: 1'b0, addr: 32'h0000_6000, be: 4'hF, wdata: mem_wdata});
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("bus_req after async reset", 32'(bus_if.bus_req), 32'd0);
        mem_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        checkOutput("reset bus_we", 32'(bus_if.bus_we), 32'd0);
        checkOutput("reset bus_addr", bus_if.bus_addr, 32'd0);
        checkOutput("reset bus_be", 32'(bus_if.bus_be), 32'd0);
        checkOutput("reset bus_wdata", bus_if.bus_wdata, 32'd0);
        checkOutput("reset ld_data", ld_data, 32'd0);
        checkOutput("reset ld_valid/exc_bus", {30'd0, ld_valid, exc_bus}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_type  = MT_W;
        mem_addr  = '0;
        mem_wdata = '0;
        #2;
        checkOutput("reset bus_req", 32'(bus_if.bus_req), 32'd0);
        checkOutput("reset stall", 32'(stall), 32'd0);
        checkOutput("reset ld_valid", 32'(ld_valid), 32'd0);
        checkOutput("reset exc_bus", 32'(exc_bus), 32'd0);
        checkOutput("reset bus_addr", bus_if.bus_addr, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed accesses");
        applyStimulus(1'b0, MT_B,  32'h0000_1003, 32'h0,         1,   32'h80FF_1234);
        applyStimulus(1'b1, MT_H,  32'h0000_2002, 32'h0000_ABCD, 0,   32'h0);
        applyStimulus(1'b0, MT_W,  32'h0000_3001, 32'h0,         0,   32'h0);
        applyStimulus(1'b1, MT_H,  32'h0000_3001, 32'h1234_5678, 0,   32'h0);
        applyStimulus(1'b0, MT_HU, 32'h0000_4002, 32'h0,         255, 32'h0);
        reset_mid_req();
        idle_cycles(4);
        applyStimulus(1'b0, MT_BU, 32'h0000_5001, 32'h0,         1,   32'h0000_9A00);
        applyStimulus(1'b1, MT_B,  32'h0000_7002, 32'h0000_00C3, 2,   32'h0);
        idle_cycles(2);
        applyStimulus(1'b0, MT_B,  32'h0000_7002, 32'h0,         0,   32'hC3C3_C3C3);
        applyStimulus(1'b0, 3'b110, 32'h0000_8000, 32'h0,        3,   32'hDEAD_BEEF);
        applyStimulus(1'b1, MT_BU, 32'h0000_9000, 32'h0,         0,   32'h0);

        $display("[TB] randomized accesses");
        for (int i = 0; i < 120; i++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                          $urandom, lat, $urandom);
            if ($urandom_range(0, 3) == 0)
                idle_cycles(int'($urandom_range(1, 3)));
        end

        idle_cycles(5);
        checkOutput("pending bus requests", 32'(req_q.size()), 32'd0);
        checkOutput("pending completions", 32'(res_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
